chu_vga_multi_sprite_core: RTL and testbench

- Parametrised multi-sprite overlay for the VGA video-slot chain; drop-in successor to single-sprite slots.
- Holds NSPR independent sprites, each with a bitmap RAM, palette, position and control. Composites them over the incoming stream by fixed priority with chroma-key transparency.
- Position updates can be deferred to frame start to prevent tearing. Output is registered with fixed 2-cycle latency; si_rgb is delayed internally to stay aligned.

---
 rtl/chu_vga_multi_sprite_core.sv | 180 ++++++++++++++++++
 tb/tb_chu_vga_multi_sprite_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_vga_multi_sprite_core.sv
// Multi-sprite overlay slot: NSPR bitmap sprites composited over si_rgb by fixed priority, 2-cycle latency.
// Optional sticky overlap flags are built only with VGA_SPRITE_COLLISION_EN defined.
module chu_vga_sprite_lane #(
  parameter int CD         = 12,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_COLOR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  ram_we,
  input  logic [ADDR_WIDTH-1:0] ram_waddr,
  input  logic [1:0]            ram_wdata,
  input  logic                  reg_we,
  input  logic [1:0]            reg_sel,
  input  logic [31:0]           wr_data,
  input  logic                  sync_mode,
  input  logic                  frame_start,
  output logic                  opaque,
  output logic [CD-1:0]         colour
);
  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);

  logic [2:0]            ctrl;  // {mirror_y, mirror_x, en}
  logic [10:0]           x0p, y0p, x0, y0;
  logic [CD-1:0]         pal [4];
  logic [1:0]            mem [2**ADDR_WIDTH];
  logic [1:0]            pix;
  logic                  hit0, hit1;
  logic [10:0]           dx, dy;
  logic [LW-1:0]         u;
  logic [LH-1:0]         v;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  unused_wr;

  assign unused_wr = ^wr_data;

  // x>=x0 guard keeps a sprite parked near 2047 from wrapping to column 0
  always_comb begin
    dx    = x - x0;
    dy    = y - y0;
    hit0  = ctrl[0] && (x >= x0) && (y >= y0) && (dx[10:LW] == '0) && (dy[10:LH] == '0);
    u     = dx[LW-1:0] ^ {LW{ctrl[1]}};
    v     = dy[LH-1:0] ^ {LH{ctrl[2]}};
    raddr = ADDR_WIDTH'({v, u});
  end

  // read-before-write: a same-address write returns the old pixel
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    pix <= mem[raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= '0;
      x0p  <= '0;
      y0p  <= '0;
      x0   <= '0;
      y0   <= '0;
      hit1 <= 1'b0;
      for (int i = 0; i < 4; i++) pal[i] <= '0;
    end else begin
      hit1 <= hit0;
      if (!sync_mode) begin
        x0 <= x0p;
        y0 <= y0p;
      end else if (frame_start) begin
        x0 <= (reg_we && reg_sel == 2'd1) ? wr_data[10:0] : x0p;
        y0 <= (reg_we && reg_sel == 2'd2) ? wr_data[10:0] : y0p;
      end
      if (reg_we) begin
        case (reg_sel)
          2'd0: ctrl <= wr_data[2:0];
          2'd1: x0p  <= wr_data[10:0];
          2'd2: y0p  <= wr_data[10:0];
          2'd3: pal[wr_data[13:12]] <= wr_data[CD-1:0];
        endcase
      end
    end
  end

  assign colour = pal[pix];
  assign opaque = hit1 && (pix != 2'd0) && (colour != CD'(KEY_COLOR));
endmodule

module chu_vga_multi_sprite_core #(
  parameter int CD         = 12,
  parameter int NSPR       = 4,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_COLOR  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  input  logic            cs,
  input  logic            write,
  input  logic [13:0]     addr,
  input  logic [31:0]     wr_data,
  input  logic [CD-1:0]   si_rgb,
  output logic [CD-1:0]   so_rgb,
  output logic [NSPR-1:0] collision
);
  logic                      wr, ram_wr, spr_wr, glb_wr, frame_start;
  logic                      bypass, sync_mode;
  logic [CD-1:0]             si1, pick;
  logic [NSPR-1:0]           opaque;
  logic [NSPR-1:0][CD-1:0]   colour;
  logic                      unused_bus;

  assign unused_bus  = ^{addr, wr_data};
  assign wr          = cs & write;
  assign ram_wr      = wr & ~addr[13];
  assign spr_wr      = wr & (addr[13:12] == 2'b10);
  assign glb_wr      = wr & (addr[13:12] == 2'b11);
  assign frame_start = (x == 11'd0) && (y == 11'd0);

  for (genvar i = 0; i < NSPR; i++) begin : g_lane
    chu_vga_sprite_lane #(
      .CD(CD), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_WIDTH(ADDR_WIDTH), .KEY_COLOR(KEY_COLOR)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .x          (x),
      .y          (y),
      .ram_we     (ram_wr && addr[12:10] == 3'(i)),
      .ram_waddr  (addr[ADDR_WIDTH-1:0]),
      .ram_wdata  (wr_data[1:0]),
      .reg_we     (spr_wr && addr[4:2] == 3'(i)),
      .reg_sel    (addr[1:0]),
      .wr_data    (wr_data),
      .sync_mode  (sync_mode),
      .frame_start(frame_start),
      .opaque     (opaque[i]),
      .colour     (colour[i])
    );
  end

  // lowest index wins, so scan from the top down
  always_comb begin
    pick = si1;
    for (int i = NSPR-1; i >= 0; i--)
      if (opaque[i]) pick = colour[i];
    if (bypass) pick = si1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypass    <= 1'b0;
      sync_mode <= 1'b0;
      si1       <= '0;
      so_rgb    <= '0;
    end else begin
      si1    <= si_rgb;
      so_rgb <= pick;
      if (glb_wr && addr[1:0] == 2'd0) bypass    <= wr_data[0];
      if (glb_wr && addr[1:0] == 2'd1) sync_mode <= wr_data[0];
    end
  end

`ifdef VGA_SPRITE_COLLISION_EN
  logic coll_clr, multi;
  assign coll_clr = glb_wr && (addr[1:0] == 2'd2);
  assign multi    = |(opaque & (opaque - NSPR'(1)));  // two or more bits set

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) collision <= '0;
    else          collision <= (coll_clr ? '0 : collision) | (multi ? opaque : '0);
  end
`else
  assign collision = '0;
`endif
endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
// Randomised bench for chu_vga_multi_sprite_core against a behavioural pixel model.
module tb_chu_vga_multi_sprite_core;
  localparam int CD = 12, NSPR = 4, SPR_W = 32, SPR_H = 32, KEY = 0;

  logic            clk = 0, reset_n = 0;
  logic [10:0]     x = 0, y = 0;
  logic            cs = 0, write = 0;
  logic [13:0]     addr = 0;
  logic [31:0]     wr_data = 0;
  logic [CD-1:0]   si_rgb = 0, so_rgb;
  logic [NSPR-1:0] collision;

  chu_vga_multi_sprite_core #(.CD(CD), .NSPR(NSPR), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .ADDR_WIDTH(10), .KEY_COLOR(KEY)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb), .collision(collision));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NSPR-1:0]      hit;
    logic [NSPR-1:0][1:0] pix;
    logic [CD-1:0]        si;
  } ent_t;

  int n_chk = 0, n_fail = 0;
  ent_t q[$];
  logic [1:0]    m_ram [NSPR][1024];
  logic [2:0]    m_ctrl[NSPR];
  logic [10:0]   m_xp[NSPR], m_yp[NSPR], m_xa[NSPR], m_ya[NSPR];
  logic [CD-1:0] m_pal[NSPR][4];
  logic          m_byp, m_sync;
  logic [NSPR-1:0] m_coll;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t model_pix(input logic [10:0] px, input logic [10:0] py, input logic [CD-1:0] si);
    ent_t e;
    e = '0;
    e.si = si;
    for (int s = 0; s < NSPR; s++) begin
      int dx = int'(px) - int'(m_xa[s]);
      int dy = int'(py) - int'(m_ya[s]);
      if (m_ctrl[s][0] && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
        int u = m_ctrl[s][1] ? SPR_W-1-dx : dx;
        int v = m_ctrl[s][2] ? SPR_H-1-dy : dy;
        e.hit[s] = 1'b1;
        e.pix[s] = m_ram[s][v*SPR_W+u];
      end
    end
    return e;
  endfunction

  function automatic void resolve(input ent_t e, output logic [CD-1:0] c, output logic [NSPR-1:0] o);
    c = e.si;
    o = '0;
    for (int s = NSPR-1; s >= 0; s--) begin
      logic [CD-1:0] pc = m_pal[s][e.pix[s]];
      if (e.hit[s] && e.pix[s] != 0 && pc != CD'(KEY)) begin
        o[s] = 1'b1;
        c = pc;
      end
    end
    if (m_byp) c = e.si;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NSPR; s++) begin
      m_ctrl[s] = 0; m_xp[s] = 0; m_yp[s] = 0; m_xa[s] = 0; m_ya[s] = 0;
      for (int k = 0; k < 4; k++) m_pal[s][k] = 0;
    end
    m_byp = 0; m_sync = 0; m_coll = 0;
    q.delete();
  endfunction

  function automatic void model_commit(input bit wr, input logic [13:0] a, input logic [31:0] d,
                                       input logic [10:0] px, input logic [10:0] py);
    int s;
    for (int i = 0; i < NSPR; i++) begin
      bit sw = wr && a[13:12] == 2'b10 && int'(a[4:2]) == i;
      if (!m_sync) begin
        m_xa[i] = m_xp[i]; m_ya[i] = m_yp[i];
      end else if (px == 0 && py == 0) begin
        m_xa[i] = (sw && a[1:0] == 1) ? d[10:0] : m_xp[i];
        m_ya[i] = (sw && a[1:0] == 2) ? d[10:0] : m_yp[i];
      end
    end
    if (!wr) return;
    if (!a[13]) begin
      s = int'(a[12:10]);
      if (s < NSPR) m_ram[s][a[9:0]] = d[1:0];
    end else if (a[12] == 1'b0) begin
      s = int'(a[4:2]);
      if (s < NSPR)
        case (a[1:0])
          2'd0: m_ctrl[s] = d[2:0];
          2'd1: m_xp[s] = d[10:0];
          2'd2: m_yp[s] = d[10:0];
          2'd3: m_pal[s][d[13:12]] = d[CD-1:0];
        endcase
    end else begin
      if (a[1:0] == 0) m_byp = d[0];
      if (a[1:0] == 1) m_sync = d[0];
    end
  endfunction

  task automatic cyc(input bit wr, input logic [13:0] a, input logic [31:0] d,
                     input logic [10:0] px, input logic [10:0] py, input logic [CD-1:0] si);
    ent_t e;
    logic [CD-1:0] exp_rgb;
    logic [NSPR-1:0] opq, newc;
    bit have;
    cs = wr; write = wr; addr = a; wr_data = d; x = px; y = py; si_rgb = si;
    q.push_back(model_pix(px, py, si));
    have = (q.size() == 2);
    newc = (wr && a[13:12] == 2'b11 && a[1:0] == 2) ? '0 : m_coll;
    exp_rgb = '0;
    if (have) begin
      e = q.pop_front();
      resolve(e, exp_rgb, opq);
      if ($countones(opq) >= 2) newc |= opq;
    end
    @(posedge clk); #1;
    if (have) chk("so_rgb", {20'd0, so_rgb}, {20'd0, exp_rgb});
`ifdef VGA_SPRITE_COLLISION_EN
    chk("collision", 32'(collision), 32'(newc));
`else
    chk("collision", 32'(collision), 32'd0);
`endif
    m_coll = newc;
    model_commit(wr, a, d, px, py);
  endtask

  function automatic logic [13:0] ra(input int s, input int r);
    return {2'b10, 7'd0, 3'(s), 2'(r)};
  endfunction
  function automatic logic [13:0] ga(input int r);
    return {2'b11, 10'd0, 2'(r)};
  endfunction

  task automatic wreg(input logic [13:0] a, input logic [31:0] d);
    cyc(1, a, d, 11'd1500, 11'd1500, CD'($urandom));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 11'd1500, 11'd1500, CD'($urandom));
  endtask
  task automatic scan(input int yy, input int xa, input int xb);
    for (int i = xa; i <= xb; i++) cyc(0, 0, 0, 11'(i), 11'(yy), CD'($urandom));
  endtask
  task automatic place(input int s, input int c, input int px, input int py);
    wreg(ra(s, 1), 32'(px)); wreg(ra(s, 2), 32'(py)); wreg(ra(s, 0), 32'(c));
  endtask

  task automatic do_reset();
    #1 reset_n = 0;
    cs = 0; write = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_so_rgb", 32'(so_rgb), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    model_reset();
    reset_n = 1;
  endtask

  initial begin
    int rx, ry;
    model_reset();
    si_rgb = 12'hABC;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 11'd1500, 11'd1500, 12'hABC);

    for (int s = 0; s < NSPR; s++)
      for (int p = 0; p < 1024; p++) begin
        logic [1:0] v;
        v = (s == 0) ? 2'd1 : (s == 3) ? ((p % SPR_W == 0) ? 2'd1 : 2'd0) : 2'($urandom);
        cyc(1, {1'b0, 3'(s), 10'(p)}, 32'(v), 11'd1500, 11'd1500, CD'($urandom));
      end
    for (int k = 1; k < 4; k++) begin
      wreg(ra(0, 3), {18'd0, 2'(k), (k == 1) ? 12'hF00 : 12'($urandom | 1)});
      wreg(ra(1, 3), {18'd0, 2'(k), (k == 2) ? 12'h000 : 12'h0F0});
      wreg(ra(2, 3), {18'd0, 2'(k), 12'($urandom | 1)});
      wreg(ra(3, 3), {18'd0, 2'(k), 12'h00F});
    end

    place(0, 1, 100, 50); idle(2);
    scan(50, 99, 132);
    place(1, 1, 110, 40); idle(2);
    scan(50, 95, 150);
    place(0, 0, 100, 50); place(1, 0, 110, 40);
    place(3, 3, 0, 0); idle(2);
    for (int yy = 0; yy < 3; yy++) scan(yy, 0, 40);
    wreg(ga(0), 1); scan(1, 0, 40); wreg(ga(0), 0);
    place(3, 0, 0, 0);

    place(0, 1, 100, 50); idle(2);
    wreg(ga(1), 1);
    wreg(ra(0, 1), 200);
    scan(50, 95, 135);
    cyc(1, ra(0, 2), 50, 0, 0, CD'($urandom));
    scan(50, 195, 235);
    wreg(ga(1), 0);
    wreg(ra(0, 1), 10);
    scan(50, 5, 45);

    place(0, 1, 300, 300); place(2, 1, 310, 300); idle(2);
    scan(300, 300, 345); idle(4);
    wreg(ga(2), 0); idle(3);
    place(2, 0, 0, 0);

    place(1, 1, 2040, 10); idle(2);
    scan(12, 2035, 2047); scan(12, 0, 10);

    rx = 0; ry = 0;
    for (int i = 0; i < 5000; i++) begin
      logic [13:0] a; logic [31:0] d; bit wr;
      wr = ($urandom % 6) == 0;
      a = 0; d = 0;
      if (wr) begin
        int s = $urandom % 8;
        case ($urandom % 8)
          0, 7: begin a = {1'b0, 3'(s), 10'($urandom)}; d = 32'($urandom % 4); end
          1: begin a = ra(s, 0); d = 32'($urandom % 8); end
          2: begin a = ra(s, 1); d = ($urandom % 4 == 0) ? 32'(2030 + $urandom % 18) : 32'($urandom % 64); end
          3: begin a = ra(s, 2); d = 32'($urandom % 40); end
          4: begin a = ra(s, 3); d = {18'd0, 2'($urandom), ($urandom % 4 == 0) ? 12'h000 : 12'($urandom)}; end
          5: begin a = ga(0); d = ($urandom % 4 == 0) ? 32'd1 : 32'd0; end
          default: begin a = ga(1 + $urandom % 3); d = 32'($urandom % 2); end
        endcase
      end
      cyc(wr, a, d, 11'(rx), 11'(ry), CD'($urandom));
      rx = (rx == 63) ? 0 : rx + 1;
      if (rx == 0) ry = (ry == 39) ? 0 : ry + 1;
    end

    do_reset();
    place(0, 1, 5, 5); idle(2);
    scan(6, 0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
